// File: rtl/deca_timer_sched_pkg.sv
// Shared constants for the interval-timer scheduler: register map, control word, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deca_timer_sched_pkg;

  // Timer s1 register addresses
  localparam logic [2:0] TM_STATUS  = 3'd0;
  localparam logic [2:0] TM_CONTROL = 3'd1;
  localparam logic [2:0] TM_PERIODL = 3'd2;
  localparam logic [2:0] TM_PERIODH = 3'd3;

  // CONTROL register bit positions
  localparam int CTL_ITO_BIT   = 0;
  localparam int CTL_CONT_BIT  = 1;
  localparam int CTL_START_BIT = 2;
  localparam int CTL_STOP_BIT  = 3;

  localparam logic [15:0] CTL_STOP      = 16'h1 << CTL_STOP_BIT;
  localparam logic [15:0] CTL_START_IRQ = (16'h1 << CTL_START_BIT) | (16'h1 << CTL_ITO_BIT);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_W_STOP, S_W_PL, S_W_PH, S_W_CLR, S_W_START, S_WAIT, S_C_STOP, S_W_ACK
  } state_e;

  // Period register value for a requested delay; the timer counts period+1 ticks.
  function automatic logic [31:0] clamp_delay(input logic [31:0] dly, input logic [31:0] min_dly);
    return ((dly < min_dly) ? min_dly : dly) - 32'd1;
  endfunction

endpackage

// File: rtl/deca_rr_arbiter.sv
// Round-robin pick of one requester, search starting at ptr_i and wrapping.
// Latency: combinational.
// Backpressure: none; vld_o low when the mask is empty.
module deca_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] mask_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             vld_o
);

  logic [IW-1:0] j;

  // First set bit of the mask at or after ptr_i, modulo N_REQ
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = IW'((int'(ptr_i) + k) % N_REQ);
      if (!vld_o && mask_i[j]) begin
        vld_o = 1'b1;
        idx_o = j;
        gnt_o = N_REQ'(1) << j;
      end
    end
  end

endmodule

// File: rtl/deca_qsys_timer_sched.sv
// Shares one interval timer among N_REQ one-shot delay requesters (round robin), pulsing done on expiry.
// Latency: ARB + 5 programming writes, then period+1 timer ticks, then irq/ack, then a one-cycle done.
// Backpressure: requesters hold req until done; timer writes take one cycle each (no waitrequest).
module deca_qsys_timer_sched
  import deca_timer_sched_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] MIN_DELAY = 32'd2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_delay,
  input  logic [N_REQ-1:0]     cancel,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic [2:0]           tm_address,
  output logic                 tm_chipselect,
  output logic                 tm_write_n,
  output logic [15:0]          tm_writedata,
  input  logic                 tm_irq
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [31:0]      dly_q, dly_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             cxl_q, cxl_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_vld;
  logic [31:0]      sel_delay;
  logic             act_cancel;

  // A requester cancelling this cycle is not eligible this cycle
  assign cand       = req & ~cancel;
  assign act_cancel = |(cancel & grant_q);
  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);

  deca_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .mask_i (cand),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  // Delay slice of the arbitration winner
  always_comb begin
    sel_delay = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IW'(i)) sel_delay = req_delay[32*i +: 32];
    end
  end

  // Next-state, timer write mux and done generation
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    dly_d         = dly_q;
    ptr_d         = ptr_q;
    cxl_d         = cxl_q;
    done_d        = '0;
    tm_chipselect = 1'b0;
    tm_write_n    = 1'b1;
    tm_address    = TM_STATUS;
    tm_writedata  = '0;
    unique case (state_q)
      S_IDLE: if (|cand) state_d = S_ARB;
      S_ARB: begin
        if (arb_vld) begin
          grant_d = arb_gnt;
          dly_d   = clamp_delay(sel_delay, MIN_DELAY);
          ptr_d   = (arb_idx == IW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
          cxl_d   = 1'b0;
          state_d = S_W_STOP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_STOP: begin
        {tm_chipselect, tm_write_n, tm_address, tm_writedata} = {2'b10, TM_CONTROL, CTL_STOP};
        state_d = act_cancel ? S_C_STOP : S_W_PL;
      end
      S_W_PL: begin
        {tm_chipselect, tm_write_n, tm_address, tm_writedata} = {2'b10, TM_PERIODL, dly_q[15:0]};
        state_d = act_cancel ? S_C_STOP : S_W_PH;
      end
      S_W_PH: begin
        {tm_chipselect, tm_write_n, tm_address, tm_writedata} = {2'b10, TM_PERIODH, dly_q[31:16]};
        state_d = act_cancel ? S_C_STOP : S_W_CLR;
      end
      S_W_CLR: begin
        {tm_chipselect, tm_write_n, tm_address, tm_writedata} = {2'b10, TM_STATUS, 16'h0000};
        state_d = act_cancel ? S_C_STOP : S_W_START;
      end
      S_W_START: begin
        {tm_chipselect, tm_write_n, tm_address, tm_writedata} = {2'b10, TM_CONTROL, CTL_START_IRQ};
        state_d = act_cancel ? S_C_STOP : S_WAIT;
      end
      // cancel wins over an irq arriving in the same cycle
      S_WAIT: begin
        if (act_cancel)  state_d = S_C_STOP;
        else if (tm_irq) state_d = S_W_ACK;
      end
      S_C_STOP: begin
        {tm_chipselect, tm_write_n, tm_address, tm_writedata} = {2'b10, TM_CONTROL, CTL_STOP};
        cxl_d   = 1'b1;
        state_d = S_W_ACK;
      end
      S_W_ACK: begin
        {tm_chipselect, tm_write_n, tm_address, tm_writedata} = {2'b10, TM_STATUS, 16'h0000};
        done_d  = cxl_q ? '0 : grant_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      dly_q   <= '0;
      ptr_q   <= '0;
      cxl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      dly_q   <= dly_d;
      ptr_q   <= ptr_d;
      cxl_q   <= cxl_d;
    end
  end

endmodule

// File: tb/tb_deca_qsys_timer_sched.sv
// Bench for the timer scheduler with a behavioural interval-timer slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_deca_qsys_timer_sched;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   cancel = '0;
  logic [32*N-1:0] req_delay = '0;
  logic [N-1:0]   done, grant;
  logic           busy;
  logic [2:0]     tm_address;
  logic           tm_chipselect, tm_write_n;
  logic [15:0]    tm_writedata;
  logic           tm_irq;

  always #5 clk = ~clk;

  deca_qsys_timer_sched #(.N_REQ(N), .MIN_DELAY(32'd2)) dut (
    .clk(clk), .reset(rst), .req(req), .req_delay(req_delay), .cancel(cancel),
    .done(done), .grant(grant), .busy(busy), .tm_address(tm_address),
    .tm_chipselect(tm_chipselect), .tm_write_n(tm_write_n),
    .tm_writedata(tm_writedata), .tm_irq(tm_irq)
  );

  // Behavioural one-shot interval timer (s1 slave); not reset by the scheduler reset
  logic [15:0] t_pl = '0, t_ph = '0;
  logic [31:0] t_cnt = '0;
  logic        t_ito = 1'b0, t_run = 1'b0, t_to = 1'b0;
  always @(posedge clk) begin
    if (t_run) begin
      if (t_cnt == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
      else t_cnt <= t_cnt - 1;
    end
    if (tm_chipselect && !tm_write_n) begin
      case (tm_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito <= tm_writedata[0];
          if (tm_writedata[3]) t_run <= 1'b0;
          if (tm_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
        end
        3'd2: t_pl <= tm_writedata;
        3'd3: t_ph <= tm_writedata;
        default: ;
      endcase
    end
  end
  assign tm_irq = t_to & t_ito;

  typedef struct { int cyc; logic [18:0] aw; logic [N-1:0] g; } wr_t;
  typedef struct { int cyc; logic [N-1:0] v; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  int          exp_idx[$];
  logic [31:0] exp_dly[$];
  bit          exp_cx[$];

  int n_cmp = 0, n_err = 0, cyc_n = 0, ptr_m = 0;
  int cx_mode = 0, cx_idx = 0, cx_after = 0, last_start = -1, reraise_cnt = 0;
  bit rearm0 = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_delay(input int i, input logic [31:0] v);
    req_delay[32*i +: 32] = v;
  endtask

  task automatic add_exp(input int i, input logic [31:0] d, input bit cx);
    exp_idx.push_back(i); exp_dly.push_back(d); exp_cx.push_back(cx);
  endtask

  // One cycle: observe at negedge, then act as the requesters would
  task automatic step();
    @(negedge clk);
    cyc_n++;
    cancel = '0;
    if (tm_chipselect && !tm_write_n) begin
      wr_q.push_back('{cyc_n, {tm_address, tm_writedata}, grant});
      if (tm_address == 3'd1 && tm_writedata == 16'h0005) last_start = cyc_n;
    end
    if (reraise_cnt > 0) begin
      reraise_cnt--;
      if (reraise_cnt == 0) req[0] = 1'b1;
    end
    if (|done) begin
      dn_q.push_back('{cyc_n, done});
      req = req & ~done;
      if (done[0] && rearm0) begin rearm0 = 1'b0; reraise_cnt = 5; end
    end
    if (cx_mode == 1 && last_start >= 0 && cyc_n == last_start + cx_after && grant[cx_idx]) begin
      cancel[cx_idx] = 1'b1; req[cx_idx] = 1'b0; cx_mode = 0;
    end
    if (cx_mode == 2 && tm_irq && busy && !tm_chipselect && grant[cx_idx]) begin
      cancel[cx_idx] = 1'b1; req[cx_idx] = 1'b0; cx_mode = 0;
    end
  endtask

  task automatic do_reset();
    req = '0; cancel = '0; rst = 1'b1; cx_mode = 0; rearm0 = 1'b0; reraise_cnt = 0;
    step(); step();
    check_eq("rst.outs", {done, grant, busy, tm_chipselect}, '0);
    check_eq("rst.bus", {tm_write_n, tm_address, tm_writedata}, {1'b1, 19'h0});
    rst = 1'b0;
    wr_q.delete(); dn_q.delete(); exp_idx.delete(); exp_dly.delete(); exp_cx.delete();
    ptr_m = 0; last_start = -1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    do begin step(); n++; end
    while ((busy || req != 0 || reraise_cnt != 0) && n < budget);
    check_eq("idle_reached", {busy, req}, '0);
    repeat (3) step();
  endtask

  // Round-robin service order for requests all raised together and held
  task automatic model_rr(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    pend = mask;
    while (pend != 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (pend[j]) begin
          add_exp(j, req_delay[32*j +: 32], 1'b0);
          pend[j] = 1'b0;
          ptr_m = (j + 1) % N;
          break;
        end
      end
    end
  endtask

  // Each service: STOP, PERIODL, PERIODH, CLR, START, [C_STOP], ACK; done D+1 ticks + pipeline later
  task automatic verify(input string nm);
    int w, d;
    w = 0; d = 0;
    for (int s = 0; s < exp_idx.size(); s++) begin
      logic [31:0] dv;
      logic [18:0] ew [7];
      int n;
      dv = (exp_dly[s] < 2) ? 32'd1 : exp_dly[s] - 32'd1;
      n  = exp_cx[s] ? 7 : 6;
      ew = '{{3'd1, 16'h0008}, {3'd2, dv[15:0]}, {3'd3, dv[31:16]}, {3'd0, 16'h0000},
             {3'd1, 16'h0005}, {3'd1, 16'h0008}, {3'd0, 16'h0000}};
      if (!exp_cx[s]) ew[5] = {3'd0, 16'h0000};
      for (int k = 0; k < n; k++) begin
        if (w + k < wr_q.size())
          check_eq($sformatf("%s.svc%0d.wr%0d", nm, s, k), wr_q[w+k].aw, ew[k]);
        else begin
          check_eq($sformatf("%s.svc%0d.wr_count", nm, s), wr_q.size(), w + k + 1);
          break;
        end
      end
      if (w < wr_q.size())
        check_eq($sformatf("%s.svc%0d.grant", nm, s), wr_q[w].g, 1 << exp_idx[s]);
      if (!exp_cx[s]) begin
        if (d < dn_q.size() && w + 4 < wr_q.size()) begin
          check_eq($sformatf("%s.svc%0d.done", nm, s), dn_q[d].v, 1 << exp_idx[s]);
          check_eq($sformatf("%s.svc%0d.done_cyc", nm, s), dn_q[d].cyc,
                   64'(wr_q[w+4].cyc) + 64'(dv) + 64'd4);
        end
        d++;
      end
      w += n;
    end
    check_eq({nm, ".wr_total"}, wr_q.size(), w);
    check_eq({nm, ".done_total"}, dn_q.size(), d);
  endtask

  function automatic logic [31:0] pick_delay();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 32'($urandom_range(0, 2));
    return 32'($urandom_range(3, 40));
  endfunction

  initial begin
    // Single request
    do_reset();
    set_delay(0, 32'd100); req = 4'b0001; add_exp(0, 32'd100, 1'b0);
    run_idle(400); verify("single");

    // Round robin with req[0] re-raised while others are served
    do_reset();
    for (int i = 0; i < N; i++) set_delay(i, 32'd10);
    rearm0 = 1'b1; req = 4'b1111;
    add_exp(0, 10, 0); add_exp(1, 10, 0); add_exp(2, 10, 0); add_exp(3, 10, 0); add_exp(0, 10, 0);
    run_idle(400); verify("rr");

    // Clamp of tiny delays
    do_reset();
    set_delay(0, 0); set_delay(1, 1); set_delay(2, 2); set_delay(3, 3);
    req = 4'b1111; model_rr(4'b1111);
    run_idle(400); verify("clamp");

    // Large delays, cancelled in WAIT after the period writes are seen
    do_reset();
    set_delay(0, 32'h0001_0000); req = 4'b0001; add_exp(0, 32'h0001_0000, 1'b1);
    cx_mode = 1; cx_idx = 0; cx_after = 5;
    run_idle(400); verify("big64k");
    do_reset();
    set_delay(3, 32'hFFFF_FFFF); req = 4'b1000; add_exp(3, 32'hFFFF_FFFF, 1'b1);
    cx_mode = 1; cx_idx = 3; cx_after = 5;
    run_idle(400); verify("bigmax");

    // Cancel active requester 1 in WAIT; requester 2 served next
    do_reset();
    set_delay(1, 32'd40); set_delay(2, 32'd10); req = 4'b0110;
    add_exp(1, 40, 1'b1); add_exp(2, 10, 1'b0);
    cx_mode = 1; cx_idx = 1; cx_after = 5;
    run_idle(400); verify("cancel");

    // Cancel in the same cycle as the irq
    do_reset();
    set_delay(1, 32'd20); req = 4'b0010; add_exp(1, 20, 1'b1);
    cx_mode = 2; cx_idx = 1;
    run_idle(400); verify("race");

    // Reset while waiting on the timer
    do_reset();
    set_delay(3, 32'd60); req = 4'b1000;
    repeat (20) step();
    check_eq("rstwait.busy_before", {busy, grant}, {1'b1, 4'b1000});
    rst = 1'b1; req = '0;
    step();
    check_eq("rstwait.after", {busy, grant, done}, '0);
    rst = 1'b0;
    wr_q.delete(); dn_q.delete();
    repeat (100) step();
    check_eq("rstwait.quiet", {wr_q.size(), dn_q.size()}, '0);
    set_delay(0, 32'd7); req = 4'b0001; add_exp(0, 7, 1'b0);
    run_idle(400); verify("rstwait");

    // Randomized rounds against the round-robin model
    do_reset();
    for (int r = 0; r < 12; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_delay(i, pick_delay());
      req = m; model_rr(m);
      run_idle(1000);
    end
    verify("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
